qrd_stream_adapter: RTL

Parametrised input-skew / output-deskew adapter for the systolic QRD core. It accepts one N×N complex matrix as a row-major element stream and stores it. It then drives the core's N skewed row inputs, with an optional appended identity block and first-flags, honouring the core's ready signal. It collects the core's skewed outputs and re-emits R, then Q^H, as a row-major valid/ready stream, with a watchdog on the core.

---
 rtl/qrd_stream_adapter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/qrd_stream_adapter.sv
// Skew/deskew adapter for the systolic QRD core: loads an NxN complex matrix,
// feeds skewed rows (with optional identity block), collects and re-streams R then Q^H.
module qrd_stream_adapter #(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 14,
    parameter int unsigned FRAC = 10,
    parameter int unsigned AUG  = 1,
    parameter int unsigned TMO  = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W-1:0]   s_r,
    input  logic [W-1:0]   s_i,
    input  logic           core_in_ready,
    output logic [N*W-1:0] row_in_r,
    output logic [N*W-1:0] row_in_i,
    output logic [N-2:0]   row_in_f,
    input  logic           core_out_valid,
    input  logic [N*W-1:0] row_out_r,
    input  logic [N*W-1:0] row_out_i,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [W-1:0]   m_r,
    output logic [W-1:0]   m_i,
    output logic           m_sel,
    output logic           m_last,
    output logic           busy,
    output logic           err
);

    localparam int unsigned C  = N * (1 + AUG);
    localparam int unsigned S  = C + N - 1;
    localparam int unsigned SW = $clog2(S + 1);
    localparam int unsigned NW = $clog2(N);
    localparam int unsigned CW = $clog2(C);
    localparam int unsigned TW = $clog2(TMO + 1);
    localparam logic [W-1:0] ONE = W'(1) << FRAC;

    typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;
    state_t state;

    logic [NW-1:0]  ld_j, ld_k, rd_j, rd_c;
    logic           rd_sel;
    logic [SW-1:0]  fstep, cstep, feed_step;
    logic [TW-1:0]  wdog;
    logic [W-1:0]   h_r [N][N];
    logic [W-1:0]   h_i [N][N];
    logic [W-1:0]   q_r [N][C];
    logic [W-1:0]   q_i [N][C];
    logic [N*W-1:0] feed_r, feed_i;
    logic [N-2:0]   feed_f;
    logic [CW-1:0]  col_idx [N];
    logic [N-1:0]   col_en;
    logic [CW-1:0]  rd_col;
    logic           last_elem, load_fire, load_done;

    assign s_ready   = (state == LOAD);
    assign load_fire = s_ready && s_valid;
    assign load_done = load_fire && ld_j == NW'(N - 1) && ld_k == NW'(N - 1);
    assign rd_col    = rd_sel ? CW'(N + 32'(rd_c)) : CW'(rd_c);
    assign last_elem = (rd_sel == 1'(AUG)) && rd_j == NW'(N - 1) && rd_c == NW'(N - 1);

    // Row values are computed for the step about to be presented so row_in stays registered.
    always_comb begin
        feed_step = (state == RUN) ? fstep + 1'b1 : '0;
        feed_r = '0;
        feed_i = '0;
        feed_f = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (k <= 32'(feed_step) && 32'(feed_step) < k + N) begin
                feed_r[k*W +: W] = h_r[k][NW'(32'(feed_step) - k)];
                feed_i[k*W +: W] = h_i[k][NW'(32'(feed_step) - k)];
            end else if (AUG != 0 && 32'(feed_step) == 2 * k + N) begin
                feed_r[k*W +: W] = ONE;
            end
        end
        for (int unsigned k = 0; k + 1 < N; k++) begin
            if (32'(feed_step) == 2 * k && 32'(feed_step) < S) feed_f[k] = 1'b1;
        end
    end

    always_comb begin
        col_en = '0;
        for (int unsigned k = 0; k < N; k++) begin
            col_idx[k] = '0;
            if (k <= 32'(cstep) && 32'(cstep) < k + C) begin
                col_en[k]  = 1'b1;
                col_idx[k] = CW'(32'(cstep) - k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_fire) begin
            h_r[ld_j][ld_k] <= s_r;
            h_i[ld_j][ld_k] <= s_i;
        end
        if (state == RUN && core_out_valid) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (col_en[k]) begin
                    q_r[k][col_idx[k]] <= row_out_r[k*W +: W];
                    q_i[k][col_idx[k]] <= row_out_i[k*W +: W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            ld_j     <= '0;
            ld_k     <= '0;
            rd_j     <= '0;
            rd_c     <= '0;
            rd_sel   <= 1'b0;
            fstep    <= '0;
            cstep    <= '0;
            wdog     <= '0;
            row_in_r <= '0;
            row_in_i <= '0;
            row_in_f <= '0;
            m_valid  <= 1'b0;
            m_r      <= '0;
            m_i      <= '0;
            m_sel    <= 1'b0;
            m_last   <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_fire) begin
                        if (ld_k == NW'(N - 1)) begin
                            ld_k <= '0;
                            ld_j <= (ld_j == NW'(N - 1)) ? '0 : ld_j + 1'b1;
                        end else begin
                            ld_k <= ld_k + 1'b1;
                        end
                    end
                    if (load_done) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        fstep    <= '0;
                        cstep    <= '0;
                        wdog     <= '0;
                        row_in_r <= feed_r;
                        row_in_i <= feed_i;
                        row_in_f <= feed_f;
                    end
                end
                RUN: begin
                    if (core_in_ready && fstep < SW'(S)) begin
                        fstep    <= fstep + 1'b1;
                        row_in_r <= feed_r;
                        row_in_i <= feed_i;
                        row_in_f <= feed_f;
                    end
                    if (core_out_valid) begin
                        wdog  <= '0;
                        cstep <= cstep + 1'b1;
                        if (cstep == SW'(S - 1)) begin
                            state    <= DRAIN;
                            rd_j     <= '0;
                            rd_c     <= '0;
                            rd_sel   <= 1'b0;
                            row_in_r <= '0;
                            row_in_i <= '0;
                            row_in_f <= '0;
                        end
                    end else if (wdog == TW'(TMO - 1)) begin
                        err      <= 1'b1;
                        state    <= LOAD;
                        busy     <= 1'b0;
                        row_in_r <= '0;
                        row_in_i <= '0;
                        row_in_f <= '0;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                DRAIN: begin
                    if (m_valid && m_ready && m_last) begin
                        state   <= LOAD;
                        busy    <= 1'b0;
                        m_valid <= 1'b0;
                        m_r     <= '0;
                        m_i     <= '0;
                        m_sel   <= 1'b0;
                        m_last  <= 1'b0;
                    end else if (!m_valid || m_ready) begin
                        m_valid <= 1'b1;
                        m_r     <= q_r[rd_j][rd_col];
                        m_i     <= q_i[rd_j][rd_col];
                        m_sel   <= rd_sel;
                        m_last  <= last_elem;
                        if (rd_c == NW'(N - 1)) begin
                            rd_c <= '0;
                            if (rd_j == NW'(N - 1)) begin
                                rd_j   <= '0;
                                rd_sel <= 1'b1;
                            end else begin
                                rd_j <= rd_j + 1'b1;
                            end
                        end else begin
                            rd_c <= rd_c + 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
